// File: rtl/imem_prefetch.sv
// Sequential instruction prefetcher: streams word addresses to ROM port A, buffers returns in a FIFO.
// Optional IMEM_PREFETCH_BYPASS_EN forwards the ROM word straight to the core when the FIFO is empty.
module imem_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        fetch_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        rom_en,
  output logic        rom_flush,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rd
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q [DEPTH];
  logic [31:0]   pc_mem_d [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   instr_mem_d [DEPTH];

  logic [CW:0]   occupancy;
  logic          fifo_empty;
  logic          bypass_hit;
  logic          pop;
  logic          fifo_pop;
  logic          push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // Credit counts the word already in flight so a response always finds room.
    occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    rom_flush  = reset | redirect;
    rom_en     = !rom_flush && (occupancy < DEPTH_W);
    rom_addr   = fetch_pc_q;
    fifo_empty = (count_q == '0);
`ifdef IMEM_PREFETCH_BYPASS_EN
    bypass_hit = fifo_empty && inflight_q;
`else
    bypass_hit = 1'b0;
`endif
    out_valid = !rom_flush && (!fifo_empty || bypass_hit);
    out_instr = bypass_hit ? rom_rd : instr_mem_q[rd_ptr_q];
    out_pc    = bypass_hit ? inflight_pc_q : pc_mem_q[rd_ptr_q];
    pop       = out_valid && fetch_ready;
    fifo_pop  = pop && !bypass_hit;
    push      = inflight_q && !(bypass_hit && pop);
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = rom_en;
    inflight_pc_d = inflight_pc_q;
    if (rom_en) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_pc_d = fetch_pc_q;
    end
    rd_ptr_d    = fifo_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d    = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    count_d     = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, fifo_pop};
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr_q]    = inflight_pc_q;
      instr_mem_d[wr_ptr_q] = rom_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else if (redirect) begin
      fetch_pc_q <= {redirect_addr[31:2], 2'b00};
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    pc_mem_q      <= pc_mem_d;
    instr_mem_q   <= instr_mem_d;
  end

endmodule

// File: tb/tb_imem_prefetch.sv
// Bench for imem_prefetch: queue-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized ready/redirect/reset traffic.
module tb_imem_prefetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IMEM_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 2;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset, redirect, fetch_ready;
  logic [31:0] redirect_addr;
  logic        out_valid, rom_en, rom_flush;
  logic [31:0] out_instr, out_pc, rom_addr;
  logic [31:0] rom_rd = 32'h0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mark  = 0;

  logic [31:0] mq[$];
  bit          m_inflight = 1'b0;
  logic [31:0] m_inflight_pc = 32'h0;
  logic [31:0] m_fetch = RESET_PC;
  bit          e_en, e_valid, e_byp, byp_taken;
  logic [31:0] e_pc;

  logic [31:0] acc_pc[$];
  logic [31:0] acc_instr[$];
  int          acc_cyc[$];

  imem_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
    .fetch_ready(fetch_ready), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .rom_en(rom_en), .rom_flush(rom_flush), .rom_addr(rom_addr), .rom_rd(rom_rd)
  );

  always #5 clk = ~clk;

  // ROM: word at byte address A holds A>>2, registered one cycle after the enable.
  always @(posedge clk) begin
    if (rom_flush) rom_rd <= 32'h0;
    else if (rom_en) rom_rd <= rom_addr >> 2;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] apc(input int i);
    return (i < acc_pc.size()) ? acc_pc[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] ains(input int i);
    return (i < acc_instr.size()) ? acc_instr[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic int acy(input int i);
    return (i < acc_cyc.size()) ? acc_cyc[i] : -1;
  endfunction

  task automatic clear_acc();
    acc_pc.delete();
    acc_instr.delete();
    acc_cyc.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare process: inputs are stable here, so the model can also take the coming edge.
  always @(negedge clk) begin
    cyc++;
    e_en    = !reset && !redirect && ((mq.size() + int'(m_inflight)) < DEPTH);
    e_byp   = BYP && (mq.size() == 0) && m_inflight;
    e_valid = !reset && !redirect && ((mq.size() > 0) || e_byp);
    e_pc    = (mq.size() > 0) ? mq[0] : m_inflight_pc;
    chk("rom_en", {31'b0, rom_en}, {31'b0, e_en});
    chk("rom_flush", {31'b0, rom_flush}, {31'b0, reset | redirect});
    chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
    if (e_valid) begin
      chk("out_pc", out_pc, e_pc);
      chk("out_instr", out_instr, e_pc >> 2);
    end
    if (e_en) chk("rom_addr", rom_addr, m_fetch);
    if (out_valid === 1'b1 && fetch_ready) begin
      acc_pc.push_back(out_pc);
      acc_instr.push_back(out_instr);
      acc_cyc.push_back(cyc);
    end
    if (reset) begin
      mq.delete();
      m_inflight = 1'b0;
      m_fetch    = RESET_PC;
    end else if (redirect) begin
      mq.delete();
      m_inflight = 1'b0;
      m_fetch    = redirect_addr & ~32'h3;
    end else begin
      byp_taken = e_byp && fetch_ready;
      if (e_valid && fetch_ready && !byp_taken) void'(mq.pop_front());
      if (m_inflight && !byp_taken) mq.push_back(m_inflight_pc);
      m_inflight = e_en;
      if (e_en) begin
        m_inflight_pc = m_fetch;
        m_fetch       = m_fetch + 32'd4;
      end
    end
  end

  initial begin
    int viol;
    reset = 1'b1; redirect = 1'b0; redirect_addr = 32'h0; fetch_ready = 1'b0;
    repeat (3) step();

    // Reset release, streaming at full rate.
    clear_acc();
    fetch_ready = 1'b1;
    reset = 1'b0;
    mark = cyc;
    repeat (10) step();
    chk("s1_latency", acy(0) - mark, LAT);
    for (int i = 0; i < 4; i++) begin
      chk("s1_pc", apc(i), 32'(i * 4));
      chk("s1_instr", ains(i), 32'(i));
    end
    chk("s1_no_gap", acy(3) - acy(0), 3);

    // Back-pressure fills the FIFO, then drains without a bubble.
    reset = 1'b1; fetch_ready = 1'b0;
    step();
    reset = 1'b0;
    repeat (10) step();
    chk("s2_full_no_issue", {31'b0, rom_en}, 32'd0);
    clear_acc();
    fetch_ready = 1'b1;
    mark = cyc;
    repeat (6) step();
    for (int i = 0; i < 5; i++) begin
      chk("s2_pc", apc(i), 32'(i * 4));
      chk("s2_cyc", acy(i) - mark, i + 1);
    end

    // Redirect with a word in flight and two buffered.
    reset = 1'b1; fetch_ready = 1'b0;
    step();
    reset = 1'b0;
    repeat (3) step();
    redirect = 1'b1; redirect_addr = 32'h43;
    #1;
    chk("s3_flush", {31'b0, rom_flush}, 32'd1);
    chk("s3_en_off", {31'b0, rom_en}, 32'd0);
    step();
    redirect = 1'b0;
    clear_acc();
    fetch_ready = 1'b1;
    mark = cyc;
    repeat (8) step();
    chk("s3_first_pc", apc(0), 32'h40);
    chk("s3_first_instr", ains(0), 32'h10);
    chk("s3_latency", acy(0) - mark, LAT);
    viol = 0;
    foreach (acc_pc[i]) if (acc_pc[i] < 32'h40) viol++;
    chk("s3_no_stale", 32'(viol), 32'd0);

    // Redirect while a head is valid and the core is ready: no transfer that cycle.
    clear_acc();
    redirect = 1'b1; redirect_addr = 32'h200;
    #1;
    chk("s4_valid_masked", {31'b0, out_valid}, 32'd0);
    step();
    redirect = 1'b0;
    chk("s4_no_xfer", 32'(acc_pc.size()), 32'd0);
    mark = cyc;
    repeat (6) step();
    chk("s4_pc0", apc(0), 32'h200);
    chk("s4_pc1", apc(1), 32'h204);
    chk("s4_latency", acy(0) - mark, LAT);

    // Wrap of the fetch address, with low address bits ignored.
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    clear_acc();
    repeat (7) step();
    chk("s5_pc0", apc(0), 32'hFFFF_FFFC);
    chk("s5_pc1", apc(1), 32'h0000_0000);
    chk("s5_pc2", apc(2), 32'h0000_0004);
    chk("s5_instr0", ains(0), 32'h3FFF_FFFF);
    chk("s5_instr2", ains(2), 32'h0000_0001);

    // Reset with a full FIFO.
    fetch_ready = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    #1;
    chk("s6_valid_rst", {31'b0, out_valid}, 32'd0);
    chk("s6_en_rst", {31'b0, rom_en}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("s6_valid_after", {31'b0, out_valid}, 32'd0);
    chk("s6_addr_after", rom_addr, RESET_PC);
    chk("s6_en_after", {31'b0, rom_en}, 32'd1);

    // Randomized traffic against the model.
    repeat (3000) begin
      step();
      fetch_ready   = ($urandom_range(0, 9) < 7);
      redirect      = ($urandom_range(0, 39) == 0);
      redirect_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                  : $urandom;
      reset         = ($urandom_range(0, 199) == 0);
    end
    reset = 1'b0; redirect = 1'b0; fetch_ready = 1'b1;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
